// File: rtl/cl_xiz_clkgen.sv
// Digital stand-in for the board PLL: two integer dividers with static duty/phase,
// both held low until a sticky lock flag rises after a fixed settling interval.
module cl_xiz_clkgen #(
  parameter real         CLKIN_FREQ  = 148.5,
  parameter int unsigned LOCK_CYCLES = 64,
  parameter int unsigned ODIV0       = 2,
  parameter int unsigned DUTY0       = 1,
  parameter int unsigned PHASE0      = 0,
  parameter int unsigned ODIV1       = 4,
  parameter int unsigned DUTY1       = 2,
  parameter int unsigned PHASE1      = 0
) (
  input  logic clkin1,
  input  logic rst_n,
  output logic clkout0,
  output logic clkout1,
  output logic pll_lock
);

  if (CLKIN_FREQ <= 0.0) begin : g_bad_freq
    $fatal(1, "cl_xiz_clkgen: CLKIN_FREQ must be positive");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
    $fatal(1, "cl_xiz_clkgen: LOCK_CYCLES must be 1..65535");
  end
  if (ODIV0 < 2 || ODIV0 > 1023) begin : g_bad_odiv0
    $fatal(1, "cl_xiz_clkgen: ODIV0 must be 2..1023");
  end
  if (ODIV1 < 2 || ODIV1 > 1023) begin : g_bad_odiv1
    $fatal(1, "cl_xiz_clkgen: ODIV1 must be 2..1023");
  end
  if (PHASE0 >= ODIV0) begin : g_bad_phase0
    $fatal(1, "cl_xiz_clkgen: PHASE0 must be < ODIV0");
  end
  if (PHASE1 >= ODIV1) begin : g_bad_phase1
    $fatal(1, "cl_xiz_clkgen: PHASE1 must be < ODIV1");
  end

  // Duty is clamped to the divide ratio so DUTY >= ODIV yields a constant-high output.
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [9:0]  WRAP0     = 10'(ODIV0 - 1);
  localparam logic [9:0]  WRAP1     = 10'(ODIV1 - 1);
  localparam logic [9:0]  PH0_C     = 10'(PHASE0);
  localparam logic [9:0]  PH1_C     = 10'(PHASE1);
  localparam logic [10:0] DUTY0_C   = (DUTY0 >= ODIV0) ? 11'(ODIV0) : 11'(DUTY0);
  localparam logic [10:0] DUTY1_C   = (DUTY1 >= ODIV1) ? 11'(ODIV1) : 11'(DUTY1);

  logic [15:0] r_lock_cnt;
  logic        r_lock;
  logic [9:0]  r_cnt0;
  logic [9:0]  r_cnt1;
  logic        r_clk0;
  logic        r_clk1;
  logic [9:0]  w_next0;
  logic [9:0]  w_next1;

  always_comb begin
    w_next0 = (r_cnt0 == WRAP0) ? 10'd0 : r_cnt0 + 10'd1;
    w_next1 = (r_cnt1 == WRAP1) ? 10'd0 : r_cnt1 + 10'd1;
  end

  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= 16'd0;
      r_lock     <= 1'b0;
      r_cnt0     <= 10'd0;
      r_cnt1     <= 10'd0;
      r_clk0     <= 1'b0;
      r_clk1     <= 1'b0;
    end else if (!r_lock) begin
      r_lock_cnt <= r_lock_cnt + 16'd1;
      // The locking edge also seeds the dividers so the first output cycle lines up with lock.
      if (r_lock_cnt == LOCK_LAST) begin
        r_lock <= 1'b1;
        r_cnt0 <= PH0_C;
        r_cnt1 <= PH1_C;
        r_clk0 <= ({1'b0, PH0_C} < DUTY0_C);
        r_clk1 <= ({1'b0, PH1_C} < DUTY1_C);
      end
    end else begin
      r_cnt0 <= w_next0;
      r_cnt1 <= w_next1;
      r_clk0 <= ({1'b0, w_next0} < DUTY0_C);
      r_clk1 <= ({1'b0, w_next1} < DUTY1_C);
    end
  end

  assign clkout0  = r_clk0;
  assign clkout1  = r_clk1;
  assign pll_lock = r_lock;

endmodule

// File: tb/tb_cl_xiz_clkgen.sv
// Bench for cl_xiz_clkgen: a default instance and a phase/duty variant share clock and
// reset; an edge-count model pushes expected {lock,clkout1,clkout0} into per-instance queues.
`timescale 1ns/1ps
module tb_cl_xiz_clkgen;

  localparam int LOCK_A = 64;
  localparam int LOCK_B = 10;

  logic clkin1;
  logic rst_n;
  logic a_c0, a_c1, a_lock;
  logic b_c0, b_c1, b_lock;

  int n_chk   = 0;
  int n_fail  = 0;
  int k_edges = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  logic [2:0] exp_qa[$];
  logic [2:0] exp_qb[$];

  cl_xiz_clkgen u_dut_a (
    .clkin1(clkin1), .rst_n(rst_n),
    .clkout0(a_c0), .clkout1(a_c1), .pll_lock(a_lock)
  );

  cl_xiz_clkgen #(
    .LOCK_CYCLES(LOCK_B), .ODIV0(2), .DUTY0(0), .PHASE0(0),
    .ODIV1(5), .DUTY1(2), .PHASE1(3)
  ) u_dut_b (
    .clkin1(clkin1), .rst_n(rst_n),
    .clkout0(b_c0), .clkout1(b_c1), .pll_lock(b_lock)
  );

  // clock: 148.5 MHz
  initial clkin1 = 1'b0;
  always #3.367 clkin1 = ~clkin1;

  always @(posedge a_lock) pulses_a++;
  always @(posedge b_lock) pulses_b++;

  // Expected outputs after k rising edges since reset release.
  function automatic logic [2:0] model(input int k, input int lk,
                                       input int od0, input int du0, input int ph0,
                                       input int od1, input int du1, input int ph1);
    int j;
    logic o0, o1;
    if (k < lk) return 3'b000;
    j  = k - lk;
    o0 = (((ph0 + j) % od0) < du0);
    o1 = (((ph1 + j) % od1) < du1);
    return {1'b1, o1, o0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k_edges);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin1);
      k_edges++;
      exp_qa.push_back(model(k_edges, LOCK_A, 2, 1, 0, 4, 2, 0));
      exp_qb.push_back(model(k_edges, LOCK_B, 2, 0, 0, 5, 2, 3));
      @(negedge clkin1);
      check("dut_a {lock,c1,c0}", {29'd0, a_lock, a_c1, a_c0}, {29'd0, exp_qa.pop_front()});
      check("dut_b {lock,c1,c0}", {29'd0, b_lock, b_c1, b_c0}, {29'd0, exp_qb.pop_front()});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    // reset hold with clock running
    repeat (2) begin
      @(negedge clkin1);
      check("reset_hold_a", {29'd0, a_lock, a_c1, a_c0}, 32'd0);
      check("reset_hold_b", {29'd0, b_lock, b_c1, b_c0}, 32'd0);
    end
    #6.5;
    rst_n   = 1'b1;
    k_edges = 0;

    // lock timing and divider patterns, including explicit edges around lock
    run_cycles(LOCK_A - 1);
    check("a_prelock_63", {31'd0, a_lock}, 32'd0);
    run_cycles(1);
    check("a_lock_edge_64", {31'd0, a_lock}, 32'd1);
    check("a_c1_high_at_lock", {31'd0, a_c1}, 32'd1);
    run_cycles(200);

    // stability run
    run_cycles(20000);
    check("a_lock_pulses_1", pulses_a, 32'd1);
    check("b_lock_pulses_1", pulses_b, 32'd1);

    // asynchronous mid-operation reset, 3 ns wide, off the clock edge
    @(posedge clkin1);
    #1.2;
    rst_n = 1'b0;
    #0.5;
    check("async_reset_a", {29'd0, a_lock, a_c1, a_c0}, 32'd0);
    check("async_reset_b", {29'd0, b_lock, b_c1, b_c0}, 32'd0);
    #2.5;
    rst_n   = 1'b1;
    k_edges = 0;

    run_cycles(LOCK_A - 1);
    check("a_relock_not_early", {31'd0, a_lock}, 32'd0);
    run_cycles(1);
    check("a_relock_edge", {31'd0, a_lock}, 32'd1);
    run_cycles(60);
    check("a_lock_pulses_2", pulses_a, 32'd2);
    check("b_lock_pulses_2", pulses_b, 32'd2);
    check("queues_drained", exp_qa.size() + exp_qb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
